// File: rtl/osc_pkg.sv
// Shared types and constants for the multimode phase-accumulator oscillator.
package osc_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SILENT = 2'd3
    } osc_mode_e;

    localparam int unsigned SHAPE_W = 16;
    localparam logic signed [SHAPE_W-1:0] SQ_PEAK = 16'sd32767;

endpackage

// File: rtl/wave_shaper.sv
// Combinational waveform shaper: maps phase bits to a signed 16-bit unit-scale sample.
module wave_shaper
    import osc_pkg::*;
(
    input  osc_mode_e                  mode,
    input  logic [SHAPE_W-1:0]         u,
    input  logic [7:0]                 d,
    input  logic [7:0]                 duty,
    output logic signed [SHAPE_W-1:0]  s
);

    always_comb begin
        s = '0;
        unique case (mode)
            MODE_SQUARE: s = (d < duty) ? SQ_PEAK : -SQ_PEAK;
            MODE_SAW:    s = {~u[15], u[14:0]};
            // Rising half: 2u - 32768; falling half: 32767 - 2(u - 32768), both in 16-bit wrap.
            MODE_TRI:    s = u[15] ? {u[14], ~u[13:0], 1'b1} : {~u[14], u[13:0], 1'b0};
            MODE_SILENT: s = '0;
        endcase
    end

endmodule

// File: rtl/multimode_oscillator.sv
// Single-voice oscillator: shadowed controls, phase accumulator, shaper, scaler, wrap delay.
module multimode_oscillator
    import osc_pkg::*;
#(
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned AMP_W   = 16,
    parameter int unsigned OUT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [PHASE_W-1:0]        phase_inc,
    input  logic [7:0]                duty,
    input  logic [AMP_W-1:0]          amplitude,
    output logic signed [OUT_W-1:0]   out,
    output logic                      wrap
);

    localparam int unsigned PROD_W = AMP_W + 17;

    osc_mode_e                  mode_s;
    logic [PHASE_W-1:0]         inc_s;
    logic [7:0]                 duty_s;
    logic [AMP_W-1:0]           amp_s;

    logic [PHASE_W-1:0]         phase;
    logic [PHASE_W-1:0]         phase_next;
    logic                       carry;
    logic                       load_shadow;
    logic signed [SHAPE_W-1:0]  shape;
    logic signed [SHAPE_W-1:0]  s_q;
    logic [AMP_W-1:0]           amp_q;
    logic [1:0]                 wrap_pipe;
    logic signed [PROD_W-1:0]   s_ext;
    logic signed [PROD_W-1:0]   a_ext;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   scaled;

    always_comb begin
        {carry, phase_next} = {1'b0, phase} + {1'b0, inc_s};
        load_shadow         = !enable || carry;
    end

    wave_shaper u_shaper (
        .mode (mode_s),
        .u    (phase[PHASE_W-1 -: SHAPE_W]),
        .d    (phase[PHASE_W-1 -: 8]),
        .duty (duty_s),
        .s    (shape)
    );

    // Amplitude travels with its sample so an update never rescales a pre-wrap sample.
    always_comb begin
        s_ext  = PROD_W'(s_q);
        a_ext  = PROD_W'($signed({1'b0, amp_q}));
        prod   = s_ext * a_ext;
        scaled = prod >>> (AMP_W - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s <= MODE_SQUARE;
            inc_s  <= '0;
            duty_s <= '0;
            amp_s  <= '0;
        end else if (load_shadow) begin
            mode_s <= osc_mode_e'(mode);
            inc_s  <= phase_inc;
            duty_s <= duty;
            amp_s  <= amplitude;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            s_q       <= '0;
            amp_q     <= '0;
            out       <= '0;
            wrap_pipe <= '0;
            wrap      <= 1'b0;
        end else if (!enable) begin
            phase     <= '0;
            s_q       <= '0;
            amp_q     <= '0;
            out       <= '0;
            wrap_pipe <= '0;
            wrap      <= 1'b0;
        end else begin
            phase     <= phase_next;
            s_q       <= shape;
            amp_q     <= amp_s;
            out       <= OUT_W'(scaled);
            wrap_pipe <= {wrap_pipe[0], carry};
            wrap      <= wrap_pipe[1];
        end
    end

endmodule

// File: tb/tb_multimode_oscillator.sv
// Directed self-checking bench for multimode_oscillator with hand-derived expected samples.
module tb_multimode_oscillator;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic [1:0]         mode;
    logic [23:0]        phase_inc;
    logic [7:0]         duty;
    logic [15:0]        amplitude;
    logic signed [31:0] out;
    logic               wrap;

    int n_tests;
    int n_fail;

    multimode_oscillator #(
        .PHASE_W (24),
        .AMP_W   (16),
        .OUT_W   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .phase_inc (phase_inc),
        .duty      (duty),
        .amplitude (amplitude),
        .out       (out),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loads shadows with enable low for one edge, then raises enable at a falling edge.
    task automatic start_run(input logic [1:0] m, input logic [23:0] inc,
                             input logic [7:0] dt, input logic [15:0] amp);
        enable    = 1'b0;
        mode      = m;
        phase_inc = inc;
        duty      = dt;
        amplitude = amp;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0;
        phase_inc = '0; duty = '0; amplitude = '0;
        #12;
        n_tests++;
        if (out !== 32'sd0) begin
            n_fail++; $display("FAIL reset_out out=%0d expected=0", out);
        end
        n_tests++;
        if (wrap !== 1'b0) begin
            n_fail++; $display("FAIL reset_wrap wrap=%b expected=0", wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out !== 32'sd0) begin
            n_fail++; $display("FAIL post_reset_out out=%0d expected=0", out);
        end
    endtask

    task automatic test_square;
        int j; int e; logic ew;
        start_run(2'd0, 24'h100000, 8'd128, 16'd32768);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            j  = k - 2;
            e  = (k < 2) ? 0 : (((j % 16) < 8) ? 32767 : -32767);
            ew = (k >= 2) && (j > 0) && (j % 16 == 0);
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL square_out k=%0d out=%0d expected=%0d", k, out, e);
            end
            n_tests++;
            if (wrap !== ew) begin
                n_fail++; $display("FAIL square_wrap k=%0d wrap=%b expected=%b", k, wrap, ew);
            end
        end
    endtask

    task automatic test_saw;
        int j; int u; int e; logic ew;
        start_run(2'd1, 24'd256, 8'd0, 16'd32768);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            e = (k < 2) ? 0 : (-32768 + (k - 2));
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL saw_step k=%0d out=%0d expected=%0d", k, out, e);
            end
        end
        start_run(2'd1, 24'h010000, 8'd0, 16'd32768);
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            j  = k - 2;
            u  = (j * 256) % 65536;
            e  = (k < 2) ? 0 : (u - 32768);
            ew = (k >= 2) && (j > 0) && (u == 0);
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL saw_out k=%0d out=%0d expected=%0d", k, out, e);
            end
            n_tests++;
            if (wrap !== ew) begin
                n_fail++; $display("FAIL saw_wrap k=%0d wrap=%b expected=%b", k, wrap, ew);
            end
        end
    endtask

    task automatic test_triangle;
        int j; int u; int e; logic ew;
        start_run(2'd2, 24'd256, 8'd0, 16'd32768);
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                j  = k - 2;
                u  = j % 65536;
                e  = (u < 32768) ? (2 * u - 32768) : (32767 - 2 * (u - 32768));
                ew = (j > 0) && (u == 0);
                n_tests++;
                if (out !== e) begin
                    n_fail++; $display("FAIL tri_out k=%0d out=%0d expected=%0d", k, out, e);
                end
                n_tests++;
                if (wrap !== ew) begin
                    n_fail++; $display("FAIL tri_wrap k=%0d wrap=%b expected=%b", k, wrap, ew);
                end
            end
        end
    endtask

    task automatic test_duty_change;
        int j; int e; logic ew;
        start_run(2'd0, 24'h100000, 8'd128, 16'd32768);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            j = k - 2;
            if (k < 2) e = 0;
            else if (k < 18) e = ((j % 16) < 8) ? 32767 : -32767;
            else e = ((j % 16) < 4) ? 16383 : -16384;
            ew = (k >= 2) && (j > 0) && (j % 16 == 0);
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL duty_chg_out k=%0d out=%0d expected=%0d", k, out, e);
            end
            n_tests++;
            if (wrap !== ew) begin
                n_fail++; $display("FAIL duty_chg_wrap k=%0d wrap=%b expected=%b", k, wrap, ew);
            end
            if (k == 5) begin
                duty      = 8'd64;
                amplitude = 16'd16384;
            end
        end
    endtask

    task automatic test_duty_edges;
        int j; int e;
        start_run(2'd0, 24'h100000, 8'd0, 16'd32768);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            e = (k < 2) ? 0 : -32767;
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL duty0_out k=%0d out=%0d expected=%0d", k, out, e);
            end
        end
        start_run(2'd0, 24'h010000, 8'd255, 16'd32768);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            j = k - 2;
            e = (k < 2) ? 0 : (((j % 256) < 255) ? 32767 : -32767);
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL duty255_out k=%0d out=%0d expected=%0d", k, out, e);
            end
        end
    endtask

    task automatic test_silent;
        int j; logic ew;
        start_run(2'd3, 24'h100000, 8'd128, 16'd32768);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            j  = k - 2;
            ew = (k >= 2) && (j > 0) && (j % 16 == 0);
            n_tests++;
            if (out !== 32'sd0) begin
                n_fail++; $display("FAIL silent_out k=%0d out=%0d expected=0", k, out);
            end
            n_tests++;
            if (wrap !== ew) begin
                n_fail++; $display("FAIL silent_wrap k=%0d wrap=%b expected=%b", k, wrap, ew);
            end
        end
    endtask

    task automatic test_disable;
        int j; int e;
        start_run(2'd1, 24'd256, 8'd0, 16'd32768);
        repeat (10) @(negedge clk);
        n_tests++;
        if (out !== -32760) begin
            n_fail++; $display("FAIL dis_before out=%0d expected=-32760", out);
        end
        enable    = 1'b0;
        mode      = 2'd0;
        phase_inc = 24'h100000;
        duty      = 8'd128;
        amplitude = 16'd32768;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (out !== 32'sd0) begin
                n_fail++; $display("FAIL dis_out k=%0d out=%0d expected=0", k, out);
            end
            n_tests++;
            if (wrap !== 1'b0) begin
                n_fail++; $display("FAIL dis_wrap k=%0d wrap=%b expected=0", k, wrap);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            j = k - 2;
            e = (k < 2) ? 0 : (((j % 16) < 8) ? 32767 : -32767);
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL reen_out k=%0d out=%0d expected=%0d", k, out, e);
            end
        end
    endtask

    task automatic test_async_reset;
        int e;
        start_run(2'd0, 24'h100000, 8'd128, 16'd32768);
        repeat (4) @(negedge clk);
        n_tests++;
        if (out !== 32767) begin
            n_fail++; $display("FAIL arst_before out=%0d expected=32767", out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out !== 32'sd0) begin
            n_fail++; $display("FAIL arst_out out=%0d expected=0", out);
        end
        enable    = 1'b0;
        phase_inc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            e = (k < 2) ? 0 : 32767;
            n_tests++;
            if (out !== e) begin
                n_fail++; $display("FAIL inc0_out k=%0d out=%0d expected=%0d", k, out, e);
            end
            n_tests++;
            if (wrap !== 1'b0) begin
                n_fail++; $display("FAIL inc0_wrap k=%0d wrap=%b expected=0", k, wrap);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_square();
        test_saw();
        test_duty_change();
        test_duty_edges();
        test_silent();
        test_disable();
        test_async_reset();
        test_triangle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
